// File: rtl/regfile_banked.sv
// Banked ARM register file (r0-r14 x 4 modes, 26 physical regs) with load-pending scoreboard; REGFILE_BYPASS_EN adds same-cycle write bypass.
// Latency: combinational reads; writes and pending updates visible after the write edge (same cycle with bypass).
// Backpressure: none; one operation per port per cycle, load hazards reported on rd_busy.
module regfile_banked #(
  parameter int WIDTH = 32,
  parameter int NRD   = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         mode,
  input  logic [4*NRD-1:0]   ra,
  input  logic [WIDTH-1:0]   r15,
  output logic [WIDTH*NRD-1:0] rd,
  output logic [NRD-1:0]     rd_busy,
  input  logic               we3,
  input  logic [3:0]         wa3,
  input  logic [WIDTH-1:0]   wd3,
  input  logic               we_ld,
  input  logic [3:0]         wa_ld,
  input  logic [1:0]         ld_mode,
  input  logic [WIDTH-1:0]   wd_ld,
  input  logic               mark_pend,
  input  logic [3:0]         pa,
  input  logic [1:0]         pmode
);

  localparam int NPHYS = 26;

  // Physical layout: 0-7 shared, 8-12 non-FIQ r8-r12, 13-17 FIQ r8-r12, 18-25 r13/r14 per mode.
  function automatic logic [4:0] phys_idx(input logic [3:0] a, input logic [1:0] m);
    logic [4:0] a5;
    a5 = {1'b0, a};
    if (a == 4'd15) return 5'd0;
    if (a < 4'd8) return a5;
    if (a < 4'd13) return (m == 2'd1) ? a5 + 5'd5 : a5;
    return 5'd18 + {2'b00, m, 1'b0} + (a5 - 5'd13);
  endfunction

  logic [WIDTH-1:0] regs [NPHYS];
  logic [NPHYS-1:0] pend;
  logic [NPHYS-1:0] pend_nxt;

  logic       w3_ok, ld_ok, p_ok;
  logic [4:0] w3_idx, ld_idx, p_idx;

  assign w3_ok  = we3 && (wa3 != 4'd15);
  assign ld_ok  = we_ld && (wa_ld != 4'd15);
  assign p_ok   = mark_pend && (pa != 4'd15);
  assign w3_idx = phys_idx(wa3, mode);
  assign ld_idx = phys_idx(wa_ld, ld_mode);
  assign p_idx  = phys_idx(pa, pmode);

  // Clear before set so a new load issue wins over the returning one.
  always_comb begin
    pend_nxt = pend;
    if (ld_ok) pend_nxt[ld_idx] = 1'b0;
    if (p_ok)  pend_nxt[p_idx]  = 1'b1;
  end

  // we3 is written last so the ALU result wins a same-register collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NPHYS; i++) regs[i] <= '0;
      pend <= '0;
    end else begin
      if (ld_ok) regs[ld_idx] <= wd_ld;
      if (w3_ok) regs[w3_idx] <= wd3;
      pend <= pend_nxt;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [3:0]       a;
    logic [4:0]       idx;
    logic [WIDTH-1:0] rdat;
    logic             busy;

    assign a   = ra[4*g +: 4];
    assign idx = phys_idx(a, mode);

    always_comb begin
      rdat = regs[idx];
      busy = pend[idx];
`ifdef REGFILE_BYPASS_EN
      if (ld_ok && (ld_idx == idx)) rdat = wd_ld;
      if (w3_ok && (w3_idx == idx)) rdat = wd3;
      if (ld_ok && (ld_idx == idx) && !(p_ok && (p_idx == idx))) busy = 1'b0;
`endif
      if (a == 4'd15) begin
        rdat = r15;
        busy = 1'b0;
      end
    end

    assign rd[WIDTH*g +: WIDTH] = rdat;
    assign rd_busy[g]           = busy;
  end

endmodule

// File: tb/tb_regfile_banked.sv
// Scoreboard bench for regfile_banked: random and directed traffic against a per-(mode,address) reference model.
// Latency: reads checked each cycle at negedge against the model state committed at the previous edge.
// Backpressure: none; stimulus applied every cycle.
module tb_regfile_banked;
    localparam int W = 32;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [1:0]     mode = '0;
    logic [4*N-1:0] ra = '0;
    logic [W-1:0]   r15 = '0;
    logic [W*N-1:0] rd;
    logic [N-1:0]   rd_busy;
    logic           we3 = 1'b0;
    logic [3:0]     wa3 = '0;
    logic [W-1:0]   wd3 = '0;
    logic           we_ld = 1'b0;
    logic [3:0]     wa_ld = '0;
    logic [1:0]     ld_mode = '0;
    logic [W-1:0]   wd_ld = '0;
    logic           mark_pend = 1'b0;
    logic [3:0]     pa = '0;
    logic [1:0]     pmode = '0;

    regfile_banked #(.WIDTH(W), .NRD(N)) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .ra(ra), .r15(r15),
        .rd(rd), .rd_busy(rd_busy),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .we_ld(we_ld), .wa_ld(wa_ld), .ld_mode(ld_mode), .wd_ld(wd_ld),
        .mark_pend(mark_pend), .pa(pa), .pmode(pmode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W*N-1:0] rd;
        logic [N-1:0]   busy;
        int             id;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_id  = 0;

    logic [W-1:0] m_reg  [4][15];
    bit           m_pend [4][15];

    function automatic bit same_phys(int m1, int a1, int m2, int a2);
        if (a1 != a2) return 1'b0;
        if (a1 < 8) return 1'b1;
        if (a1 < 13) return (m1 == 1) == (m2 == 1);
        return m1 == m2;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 4; m++)
            for (int a = 0; a < 15; a++) begin
                m_reg[m][a]  = '0;
                m_pend[m][a] = 1'b0;
            end
    endtask

    task automatic model_update();
        logic [W-1:0] nr [4][15];
        bit           np [4][15];
        nr = m_reg;
        np = m_pend;
        for (int m = 0; m < 4; m++)
            for (int a = 0; a < 15; a++) begin
                if (we_ld && wa_ld != 4'd15 && same_phys(int'(ld_mode), int'(wa_ld), m, a)) begin
                    nr[m][a] = wd_ld;
                    np[m][a] = 1'b0;
                end
                if (we3 && wa3 != 4'd15 && same_phys(int'(mode), int'(wa3), m, a))
                    nr[m][a] = wd3;
                if (mark_pend && pa != 4'd15 && same_phys(int'(pmode), int'(pa), m, a))
                    np[m][a] = 1'b1;
            end
        m_reg  = nr;
        m_pend = np;
    endtask

    task automatic push_zero();
        exp_t e;
        e.rd   = '0;
        e.busy = '0;
        e.id   = n_id;
        n_id++;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        e.rd   = '0;
        e.busy = '0;
        for (int p = 0; p < N; p++) begin
            logic [3:0] a;
            a = ra[4*p +: 4];
            if (a == 4'd15) begin
                e.rd[W*p +: W] = r15;
                e.busy[p]      = 1'b0;
            end else begin
                e.rd[W*p +: W] = m_reg[mode][a];
                e.busy[p]      = m_pend[mode][a];
            end
        end
        e.id = n_id;
        n_id++;
        sb.push_back(e);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clr();
        we3 = 1'b0;
        we_ld = 1'b0;
        mark_pend = 1'b0;
    endtask

    task automatic rd3(input logic [1:0] m, input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        mode = m;
        ra   = {a2, a1, a0};
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            if (rd !== e.rd || rd_busy !== e.busy) begin
                n_err++;
                $display("FAIL vec%0d mode=%0d ra=%h rd=%h exp %h busy=%b exp %b",
                         e.id, mode, ra, rd, e.rd, rd_busy, e.busy);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rd3(2'd0, 4'd1, 4'd13, 4'd8);
        #2 push_zero();
        if (rd !== '0 || rd_busy !== '0) begin
            n_err++;
            $display("FAIL in reset: rd=%h busy=%b", rd, rd_busy);
        end
        #10 reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int m = 0; m < 4; m++)
            for (int a = 0; a <= 12; a += 3) begin
                clr();
                rd3(2'(m), 4'(a), 4'(a + 1), 4'(a + 2));
                step();
            end
        r15 = 32'h108;
        rd3(2'd0, 4'd15, 4'd15, 4'd0);
        step();

        clr(); mode = 2'd0; we3 = 1'b1; wa3 = 4'd13; wd3 = 32'hAAAA0000; step();
        clr(); mode = 2'd3; we3 = 1'b1; wa3 = 4'd13; wd3 = 32'h5555;     step();
        clr(); mode = 2'd1; we3 = 1'b1; wa3 = 4'd8;  wd3 = 32'h88;       step();
        clr(); mode = 2'd2; we3 = 1'b1; wa3 = 4'd0;  wd3 = 32'hC0;       step();
        clr(); rd3(2'd0, 4'd13, 4'd8, 4'd0);  step();
        clr(); rd3(2'd3, 4'd13, 4'd8, 4'd0);  step();
        clr(); rd3(2'd1, 4'd8, 4'd13, 4'd0);  step();
        clr(); rd3(2'd2, 4'd0, 4'd13, 4'd8);  step();

        clr(); mark_pend = 1'b1; pa = 4'd4; pmode = 2'd0; rd3(2'd0, 4'd4, 4'd4, 4'd4); step();
        clr(); rd3(2'd0, 4'd4, 4'd0, 4'd1); step();
        clr(); we_ld = 1'b1; wa_ld = 4'd4; ld_mode = 2'd0; wd_ld = 32'h1234; step();
        clr(); step();

        clr(); mark_pend = 1'b1; pa = 4'd5; pmode = 2'd0; rd3(2'd0, 4'd5, 4'd6, 4'd4); step();
        clr(); we3 = 1'b1; wa3 = 4'd5; wd3 = 32'h1;
        we_ld = 1'b1; wa_ld = 4'd5; ld_mode = 2'd0; wd_ld = 32'h2; step();
        clr(); step();
        clr(); mark_pend = 1'b1; pa = 4'd6; pmode = 2'd0; step();
        clr(); mark_pend = 1'b1; pa = 4'd6; pmode = 2'd0;
        we_ld = 1'b1; wa_ld = 4'd6; ld_mode = 2'd0; wd_ld = 32'h66; step();
        clr(); step();

        clr(); mode = 2'd2; mark_pend = 1'b1; pa = 4'd14; pmode = 2'd2; rd3(2'd2, 4'd14, 4'd13, 4'd14); step();
        clr(); mode = 2'd0; we_ld = 1'b1; wa_ld = 4'd14; ld_mode = 2'd2; wd_ld = 32'hE1E1; rd3(2'd0, 4'd14, 4'd13, 4'd14); step();
        clr(); rd3(2'd2, 4'd14, 4'd13, 4'd5); step();
        clr(); rd3(2'd0, 4'd14, 4'd13, 4'd5); step();

        clr(); we3 = 1'b1; wa3 = 4'd15; wd3 = 32'hDEAD;
        we_ld = 1'b1; wa_ld = 4'd15; ld_mode = 2'd1; wd_ld = 32'hBEEF;
        mark_pend = 1'b1; pa = 4'd15; pmode = 2'd3; step();
        for (int m = 0; m < 4; m++)
            for (int a = 0; a <= 12; a += 3) begin
                clr();
                rd3(2'(m), 4'(a), 4'(a + 1), 4'(a + 2));
                step();
            end

        for (int i = 0; i < 2000; i++) begin
            mode      = 2'($urandom);
            ra        = 12'($urandom);
            r15       = $urandom;
            we3       = 1'($urandom_range(0, 1));
            wa3       = 4'($urandom);
            wd3       = $urandom;
            we_ld     = ($urandom_range(0, 2) == 0);
            wa_ld     = 4'($urandom);
            ld_mode   = 2'($urandom);
            wd_ld     = $urandom;
            mark_pend = ($urandom_range(0, 2) == 0);
            pa        = 4'($urandom);
            pmode     = 2'($urandom);
            step();
        end

        clr(); mark_pend = 1'b1; pa = 4'd7; pmode = 2'd0; step();
        clr(); mode = 2'd0; rd3(2'd0, 4'd3, 4'd7, 4'd13);
        we3 = 1'b1; wa3 = 4'd3; wd3 = 32'h3333;
        we_ld = 1'b1; wa_ld = 4'd13; ld_mode = 2'd0; wd_ld = 32'hD0D0;
        mark_pend = 1'b1; pa = 4'd2; pmode = 2'd0;
        #2 reset_n = 1'b0;
        push_zero();
        #1;
        if (rd !== '0 || rd_busy !== '0) begin
            n_err++;
            $display("FAIL async reset: rd=%h busy=%b", rd, rd_busy);
        end
        @(posedge clk);
        #1 push_zero();
        @(negedge clk);
        #1 clr();
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        clr(); rd3(2'd0, 4'd3, 4'd7, 4'd13); step();
        clr(); rd3(2'd0, 4'd2, 4'd4, 4'd14); step();
        clr(); rd3(2'd1, 4'd8, 4'd13, 4'd14); step();

        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard not drained: %0d left", sb.size());
        end
        if (n_vec < 2050) begin
            n_err++;
            $display("FAIL only %0d vectors checked", n_vec);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        if (n_err != 0) $display("FAIL");
        else $display("PASS");
        $finish;
    end

endmodule
